// File: rtl/parallel_to_serial_right_pkg.sv
// Shared definitions for the parallel/serial converters: state encoding and
// beat/counter sizing helpers.
package parallel_to_serial_right_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    SHIFTING = 1'b1
  } state_t;

  // Number of serial beats needed to carry one parallel word.
  function automatic int calc_beats(input int width, input int serial_width);
    return width / serial_width;
  endfunction

  // Beat counter width; a single-beat word still needs a one-bit counter.
  function automatic int calc_count_width(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/parallel_to_serial_right_shifter_right.sv
// Static right shifter: moves the word down by SHIFT bits and fills the
// vacated MSBs with PAD_VALUE.
module shifter_right #(
  parameter int   WIDTH     = 8,
  parameter int   SHIFT     = 1,
  parameter logic PAD_VALUE = 1'b0
) (
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    if (gi + SHIFT < WIDTH) begin : g_move
      assign data_out[gi] = data_in[gi + SHIFT];
    end else begin : g_pad
      assign data_out[gi] = PAD_VALUE;
    end
  end

endmodule

// File: rtl/parallel_to_serial_right.sv
// Parallel-to-serial converter, LSB-first, valid/ready on both sides.
// Define PARALLEL_TO_SERIAL_RIGHT_BACK_TO_BACK_EN for zero-bubble word streaming.
module parallel_to_serial_right
  import parallel_to_serial_right_pkg::*;
#(
  parameter int   WIDTH        = 8,
  parameter int   SERIAL_WIDTH = 1,
  parameter logic PAD_VALUE    = 1'b0
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic [WIDTH-1:0]        parallel_data,
  input  logic                    parallel_valid,
  output logic                    parallel_ready,
  output logic [SERIAL_WIDTH-1:0] serial_data,
  output logic                    serial_valid,
  input  logic                    serial_ready,
  output logic                    serial_last,
  output logic                    busy
);

  localparam int BEATS = calc_beats(WIDTH, SERIAL_WIDTH);
  localparam int CNT_W = calc_count_width(BEATS);
  localparam logic [CNT_W-1:0] LAST_LOAD = CNT_W'(BEATS - 1);

  if (SERIAL_WIDTH < 1 || SERIAL_WIDTH > WIDTH || (WIDTH % SERIAL_WIDTH) != 0) begin : g_param_check
    $error("parallel_to_serial_right: SERIAL_WIDTH must divide WIDTH and lie in 1..WIDTH");
  end

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   shift_reg, shift_next, shifted;
  logic [CNT_W-1:0]   beat_count_reg, beat_count_next;
  logic               serial_hs, parallel_hs;

  shifter_right #(
    .WIDTH     (WIDTH),
    .SHIFT     (SERIAL_WIDTH),
    .PAD_VALUE (PAD_VALUE)
  ) u_shifter (
    .data_in  (shift_reg),
    .data_out (shifted)
  );

  assign serial_valid = (state_reg == SHIFTING);
  assign serial_last  = serial_valid && (beat_count_reg == '0);
  assign busy         = serial_valid;
  assign serial_data  = shift_reg[SERIAL_WIDTH-1:0];

`ifdef PARALLEL_TO_SERIAL_RIGHT_BACK_TO_BACK_EN
  // Accept the next word in the same cycle the last beat leaves.
  assign parallel_ready = (state_reg == IDLE) || (serial_last && serial_ready);
`else
  assign parallel_ready = (state_reg == IDLE);
`endif

  assign serial_hs   = serial_valid && serial_ready;
  assign parallel_hs = parallel_valid && parallel_ready;

  always_comb begin
    state_next      = state_reg;
    shift_next      = shift_reg;
    beat_count_next = beat_count_reg;
    if (serial_hs) begin
      shift_next      = shifted;
      beat_count_next = beat_count_reg - CNT_W'(1);
      if (serial_last) begin
        state_next = IDLE;
      end
    end
    // A load wins over the final shift so a reloaded word is not lost.
    if (parallel_hs) begin
      shift_next      = parallel_data;
      beat_count_next = LAST_LOAD;
      state_next      = SHIFTING;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_reg      <= IDLE;
      shift_reg      <= {WIDTH{PAD_VALUE}};
      beat_count_reg <= '0;
    end else begin
      state_reg      <= state_next;
      shift_reg      <= shift_next;
      beat_count_reg <= beat_count_next;
    end
  end

endmodule

// File: tb/tb_parallel_to_serial_right.sv
// Bench for parallel_to_serial_right: three instances (1-, 4- and 8-bit beats)
// checked every cycle against a beat-queue model plus directed literal checks.
module tb_parallel_to_serial_right;

  logic clock = 1'b0;
  logic resetn = 1'b1;
  always #5 clock = ~clock;

  logic [7:0] pd [3];
  logic       pv [3];
  logic       sr [3];
  logic       pr [3];
  logic       sv [3];
  logic       sl [3];
  logic       bz [3];
  logic [7:0] sd [3];
  logic [0:0] sd_a;
  logic [3:0] sd_b;
  logic [7:0] sd_c;

  assign sd[0] = {7'b0, sd_a};
  assign sd[1] = {4'b0, sd_b};
  assign sd[2] = sd_c;

  int sw_tab [3] = '{1, 4, 8};
  logic pad_tab [3] = '{1'b0, 1'b1, 1'b0};

  int vectors = 0;
  int miscompares = 0;

  parallel_to_serial_right #(.WIDTH(8), .SERIAL_WIDTH(1), .PAD_VALUE(1'b0)) u_a (
    .clock(clock), .resetn(resetn), .parallel_data(pd[0]), .parallel_valid(pv[0]),
    .parallel_ready(pr[0]), .serial_data(sd_a), .serial_valid(sv[0]),
    .serial_ready(sr[0]), .serial_last(sl[0]), .busy(bz[0]));

  parallel_to_serial_right #(.WIDTH(8), .SERIAL_WIDTH(4), .PAD_VALUE(1'b1)) u_b (
    .clock(clock), .resetn(resetn), .parallel_data(pd[1]), .parallel_valid(pv[1]),
    .parallel_ready(pr[1]), .serial_data(sd_b), .serial_valid(sv[1]),
    .serial_ready(sr[1]), .serial_last(sl[1]), .busy(bz[1]));

  parallel_to_serial_right #(.WIDTH(8), .SERIAL_WIDTH(8), .PAD_VALUE(1'b0)) u_c (
    .clock(clock), .resetn(resetn), .parallel_data(pd[2]), .parallel_valid(pv[2]),
    .parallel_ready(pr[2]), .serial_data(sd_c), .serial_valid(sv[2]),
    .serial_ready(sr[2]), .serial_last(sl[2]), .busy(bz[2]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each instance owns a queue of beats still to be emitted.
  logic [7:0] mq [3][$];

  always @(negedge clock) begin
    logic [7:0] mask, exp_data;
    logic       empty, exp_last, exp_pr;
    int         sw;
    if (!resetn) begin
      for (int i = 0; i < 3; i++) mq[i].delete();
    end
    for (int i = 0; i < 3; i++) begin
      sw       = sw_tab[i];
      mask     = 8'((1 << sw) - 1);
      empty    = (mq[i].size() == 0);
      exp_last = (mq[i].size() == 1);
      exp_data = empty ? (pad_tab[i] ? mask : 8'h00) : mq[i][0];
`ifdef PARALLEL_TO_SERIAL_RIGHT_BACK_TO_BACK_EN
      exp_pr = empty || (exp_last && sr[i]);
`else
      exp_pr = empty;
`endif
      check($sformatf("dut%0d v/last/busy/rdy/data", i),
            {19'b0, sv[i], sl[i], bz[i], pr[i], sd[i]},
            {19'b0, !empty, exp_last, !empty, exp_pr, exp_data});
      if (resetn) begin
        if (!empty && sr[i]) void'(mq[i].pop_front());
        if (pv[i] && exp_pr) begin
          for (int k = 0; k < 8 / sw; k++) mq[i].push_back((pd[i] >> (k * sw)) & mask);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load(input int i, input logic [7:0] w);
    pd[i] = w;
    pv[i] = 1'b1;
    tick();
    pv[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i);
    for (int c = 0; c < 40 && bz[i]; c++) tick();
    check($sformatf("dut%0d idle", i), bz[i], 0);
  endtask

  // Streams a list of words into instance i, collecting beat/gap statistics.
  task automatic stream(input int i, input logic [7:0] w0, input logic [7:0] w1,
                        input int want_beats, output int beats, output int gaps);
    int  words;
    logic hs;
    beats = 0; gaps = 0; words = 0;
    pd[i] = w0; pv[i] = 1'b1;
    for (int c = 0; c < 60 && beats < want_beats; c++) begin
      @(negedge clock);
      hs = pv[i] && pr[i];
      if (sv[i]) beats++;
      else if (beats > 0 && beats < want_beats) gaps++;
      @(posedge clock);
      #1;
      if (hs) begin
        words++;
        if (words == 1) pd[i] = w1;
        else pv[i] = 1'b0;
      end
    end
    pv[i] = 1'b0;
  endtask

  initial begin
    logic [7:0] w;
    logic [7:0] words6 [2];
    int beats, gaps, n, exp_gaps;
    for (int i = 0; i < 3; i++) begin
      pd[i] = 8'h00; pv[i] = 1'b0; sr[i] = 1'b1;
    end
    #2 resetn = 1'b0;
    #1;
    check("reset a valid", sv[0], 0);
    check("reset a ready", pr[0], 1);
    check("reset b pad data", sd[1], 8'h0F);
    check("reset b last", sl[1], 0);
    tick(); tick();
    resetn = 1'b1;
    tick();

    // Basic LSB-first serialization
    w = 8'hA5;
    load(0, w);
    for (int b = 0; b < 8; b++) begin
      check($sformatf("t1 bit%0d", b), sd[0], {7'b0, w[b]});
      check($sformatf("t1 last%0d", b), sl[0], (b == 7));
      tick();
    end
    check("t1 busy after", bz[0], 0);

    // Four-bit beats with PAD_VALUE=1
    load(1, 8'h3C);
    check("t2 beat0", sd[1], 8'h0C);
    check("t2 last0", sl[1], 0);
    tick();
    check("t2 shift_reg", u_b.shift_reg, 8'hF3);
    check("t2 beat1", sd[1], 8'h03);
    check("t2 last1", sl[1], 1);
    tick();
    check("t2 busy after", bz[1], 0);

    // Backpressure on beat 2
    load(0, 8'hA5);
    tick(); tick();
    sr[0] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("t3 stall data", sd[0], 1);
      check("t3 stall valid", sv[0], 1);
      tick();
    end
    sr[0] = 1'b1;
    wait_idle(0);

    // Two consecutive words
    stream(0, 8'hFF, 8'h00, 16, beats, gaps);
`ifdef PARALLEL_TO_SERIAL_RIGHT_BACK_TO_BACK_EN
    exp_gaps = 0;
`else
    exp_gaps = 1;
`endif
    check("t4 beats", beats, 16);
    check("t4 gap cycles", gaps, exp_gaps);
    wait_idle(0);

    // Asynchronous reset in the middle of a word
    load(0, 8'hA5);
    tick(); tick(); tick();
    resetn = 1'b0;
    #1;
    check("t5 valid in reset", sv[0], 0);
    check("t5 ready in reset", pr[0], 1);
    tick(); tick();
    resetn = 1'b1;
    tick();
    w = 8'h01;
    load(0, w);
    for (int b = 0; b < 8; b++) begin
      check($sformatf("t5 bit%0d", b), sd[0], {7'b0, w[b]});
      tick();
    end
    check("t5 busy after", bz[0], 0);

    // Single-beat words
    words6[0] = 8'h12;
    words6[1] = 8'h34;
    n = 0;
    pd[2] = words6[0]; pv[2] = 1'b1;
    for (int c = 0; c < 20 && n < 2; c++) begin
      logic hs;
      @(negedge clock);
      hs = pv[2] && pr[2];
      if (sv[2]) begin
        check($sformatf("t6 word%0d", n), sd[2], words6[n]);
        check($sformatf("t6 last%0d", n), sl[2], 1);
        n++;
      end
      @(posedge clock);
      #1;
      if (hs) begin
        if (pd[2] == words6[0]) pd[2] = words6[1];
        else pv[2] = 1'b0;
      end
    end
    pv[2] = 1'b0;
    check("t6 words seen", n, 2);
    wait_idle(2);

    tick(); tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/parallel_to_serial_right.md
Name: parallel_to_serial_right

Overview:
- Sequential serializer built around the static right-shifter stage.
- Accepts a WIDTH-bit parallel word over a valid/ready handshake, then emits it LSB-first as SERIAL_WIDTH-bit beats over a second valid/ready handshake.
- After each accepted beat, the word is shifted right by SERIAL_WIDTH and padded with PAD_VALUE.
- Sits downstream of datapath producers and upstream of narrow links, e.g. UART/SPI transmit paths.

Parameters:
- WIDTH, 8, width of the parallel input word.
- SERIAL_WIDTH, 1, bits emitted per beat. Must satisfy 1 ≤ SERIAL_WIDTH ≤ WIDTH and WIDTH % SERIAL_WIDTH == 0; violation is an elaboration error.
- PAD_VALUE, 1'b0, bit shifted into the MSBs on each shift.

Ports:
- clock  input  1  clock; all state changes on the rising edge.
- resetn  input  1  asynchronous active-low reset.
- parallel_data  input  WIDTH  word to serialize.
- parallel_valid  input  1  parallel_data is valid.
- parallel_ready  output  1  block can accept a word this cycle.
- serial_data  output  SERIAL_WIDTH  current beat, equal to shift_reg[SERIAL_WIDTH-1:0].
- serial_valid  output  1  serial_data is valid.
- serial_ready  input  1  sink accepts the beat this cycle.
- serial_last  output  1  current beat is the final beat of the word.
- busy  output  1  a word is in flight (state SHIFTING).

Behaviour:
- Interface: one clock `clock`; reset `resetn` is asynchronous and active-low.
- BEATS = WIDTH/SERIAL_WIDTH. Beat counter width = max(1, clog2(BEATS)).
- Registers: state, shift_reg[WIDTH], beat_count.
- Reset values:
  - state = IDLE, shift_reg = all PAD_VALUE, beat_count = 0.
  - Hence serial_valid = 0, serial_last = 0, busy = 0, serial_data = PAD bits, parallel_ready = 1 (from IDLE).
- IDLE:
  - parallel_ready = 1, serial_valid = 0.
  - On parallel_valid & parallel_ready: shift_reg <= parallel_data, beat_count <= BEATS-1, go to SHIFTING.
- SHIFTING:
  - serial_valid = 1; serial_last = (beat_count == 0).
  - On serial_valid & serial_ready:
    - shift_reg <= shift_reg >> SERIAL_WIDTH with PAD_VALUE fill, implemented by a shifter_right instance with SHIFT = SERIAL_WIDTH.
    - beat_count decrements.
  - On the last-beat handshake: go to IDLE, unless a new word is loaded the same cycle (see Optional Feature).
- Backpressure: while serial_valid & !serial_ready, serial_data, serial_last and the internal state are held stable.
- Latency: first beat is valid the cycle after the parallel handshake. A word occupies BEATS serial handshakes.
- BEATS == 1: every beat is last; the block acts as a 1-deep register slice.
- parallel_valid in SHIFTING with the feature disabled: ignored (parallel_ready = 0); the word is not consumed.
- Reset mid-word: the in-flight word is discarded; no further beats are emitted.
- No combinational path from parallel_* to serial_*.

Optional Feature:
- Macro: PARALLEL_TO_SERIAL_RIGHT_BACK_TO_BACK_EN.
- Defined:
  - parallel_ready = IDLE | (SHIFTING & serial_last & serial_ready).
  - A simultaneous last-beat handshake and parallel handshake reloads shift_reg and beat_count and stays in SHIFTING.
  - Gives zero-bubble streaming. Creates a combinational serial_ready→parallel_ready path.
- Undefined:
  - parallel_ready = (state == IDLE), purely registered.
  - One idle cycle between consecutive words.

Decomposition:
- Shared package/header: state encoding localparams (IDLE = 1'b0, SHIFTING = 1'b1) and the BEATS / counter-width derivation helper, for reuse by a future serial_to_parallel block.
- Sub-module: one shifter_right instance (SHIFT = SERIAL_WIDTH, PAD_VALUE passed through) computes the next shift_reg. No other sub-modules.

Test Plan:
1. Basic LSB-first: WIDTH=8, SERIAL_WIDTH=1, load 8'hA5, serial_ready=1.
   -> serial_data = 1,0,1,0,0,1,0,1 on 8 consecutive cycles; serial_last only on the 8th; returns to IDLE with busy=0.
2. Multi-bit beats: SERIAL_WIDTH=4, load 8'h3C.
   -> beats 4'hC then 4'h3; serial_last on the 2nd. Internal shift_reg after the first shift = 8'h03 (PAD_VALUE=0) or 8'hF3 (PAD_VALUE=1).
3. Backpressure: load 8'hA5, drop serial_ready for 3 cycles after beat 2.
   -> serial_data stays 1 (bit 2) and serial_valid stays 1 during the stall; the full sequence completes with no loss or duplication.
4. Back-to-back: two words 8'hFF, 8'h00 presented continuously.
   -> with the macro: 16 contiguous valid beats (8×1 then 8×0). Without it: exactly one serial_valid=0 cycle between the words.
5. Reset mid-word: assert resetn=0 after beat 3 of 8'hA5.
   -> serial_valid=0 and parallel_ready=1 immediately (asynchronous). After release, the next load 8'h01 emits 1,0,0,0,0,0,0,0 with no remnant bits.
6. Degenerate BEATS=1: SERIAL_WIDTH=WIDTH=8, stream 8'h12, 8'h34.
   -> each word appears whole with serial_last=1 on every beat.
